tia_lfsr_counter: RTL

- Parametrised two-phase LFSR counter; the next generation of the TIA horizontal-timing LFSR.
- Adds four things the 6-bit fixed counter lacks: configurable width/taps, automatic wrap at a terminal state, a bank of registered state decodes, and clear/hold control with lock-up recovery.
- Serves as the common timebase for the horizontal sync counter and the object position counters (player, missile, ball).

---
 rtl/tia_lfsr_counter_pkg.sv | 32 +++
 rtl/tia_lfsr_counter_if.sv | 27 ++
 rtl/tia_lfsr_decode.sv | 21 ++
 rtl/tia_lfsr_counter.sv | 118 +++++++++++
 4 files changed

// File: rtl/tia_lfsr_counter_pkg.sv
// Shared definitions for the TIA LFSR timebase: the default HSYNC constants,
// the feedback and lock-up helpers, and the stage-source selector.
package tia_lfsr_counter_pkg;

    localparam logic [5:0] HS_RESET = 6'b000000;
    localparam logic [5:0] HS_WRAP  = 6'b010100;
    // Entry 0 is the least significant slice: SHS, RHS, RCB, END (lock-up pattern).
    localparam logic [23:0] HS_DECODES = {6'b111111, 6'b101101, 6'b110111, 6'b011100};

    typedef enum logic [2:0] {
        SEL_CLEAR  = 3'd0,
        SEL_LOCKUP = 3'd1,
        SEL_WRAP   = 3'd2,
        SEL_HOLD   = 3'd3,
        SEL_STEP   = 3'd4
    } next_sel_e;

    function automatic logic lfsr_feedback(input logic [15:0] state,
                                           input logic [3:0]  tap_a,
                                           input logic [3:0]  tap_b);
        return ~(state[tap_a] ^ state[tap_b]);
    endfunction

    // Bits above msb are forced to one so only the live width is compared.
    function automatic logic is_lockup(input logic [15:0] state,
                                       input logic [3:0]  msb);
        logic [15:0] mask;
        mask = 16'hFFFF >> (4'd15 - msb);
        return &(state | ~mask);
    endfunction

endpackage

// File: rtl/tia_lfsr_counter_if.sv
// Phase-control inputs and counter outputs of the LFSR timebase, plus a
// direct state-load hook used to reach the otherwise unreachable lock-up state.
interface tia_lfsr_counter_if #(
    parameter int WIDTH       = 6,
    parameter int NUM_DECODES = 4
);
    logic                   s1_en;
    logic                   s2_en;
    logic                   clear;
    logic                   hold;
    logic                   tst_load;
    logic [WIDTH-1:0]       tst_value;
    logic [WIDTH-1:0]       out;
    logic                   wrap;
    logic [NUM_DECODES-1:0] decode;
    logic                   lockup;

    modport master (
        output s1_en, s2_en, clear, hold, tst_load, tst_value,
        input  out, wrap, decode, lockup
    );

    modport slave (
        input  s1_en, s2_en, clear, hold, tst_load, tst_value,
        output out, wrap, decode, lockup
    );
endinterface

// File: rtl/tia_lfsr_decode.sv
// Comparator bank matching the staged LFSR state against a packed list of constants.
module tia_lfsr_decode
    import tia_lfsr_counter_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int NUM_DECODES = 4,
    parameter logic [NUM_DECODES*WIDTH-1:0] DECODE_VALUES = HS_DECODES
) (
    input  logic [WIDTH-1:0]       i_stage,
    output logic [NUM_DECODES-1:0] o_match
);

    // One equality compare per decode entry.
    always_comb begin
        o_match = {NUM_DECODES{1'b0}};
        for (int i = 0; i < NUM_DECODES; i++) begin
            o_match[i] = (i_stage == DECODE_VALUES[i*WIDTH +: WIDTH]);
        end
    end

endmodule

// File: rtl/tia_lfsr_counter.sv
// Two-phase LFSR counter: s1 computes the next state into a stage register,
// s2 commits it to the outputs together with wrap and decode flags.
module tia_lfsr_counter
    import tia_lfsr_counter_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int TAP_A       = 1,
    parameter int TAP_B       = 0,
    parameter logic [15:0] RESET_VALUE = 16'(HS_RESET),
    parameter logic [15:0] WRAP_VALUE  = 16'(HS_WRAP),
    parameter int NUM_DECODES = 4,
    parameter logic [NUM_DECODES*WIDTH-1:0] DECODE_VALUES = HS_DECODES
) (
    input logic                clk,
    input logic                reset,
    tia_lfsr_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] WRP_V = WRAP_VALUE[WIDTH-1:0];
    localparam logic [3:0]       MSB   = 4'(WIDTH - 1);

    if (WIDTH < 3 || WIDTH > 16 || TAP_A == TAP_B || TAP_A >= WIDTH || TAP_B >= WIDTH ||
        NUM_DECODES < 1 || NUM_DECODES > 8) begin : g_bad_params
        $error("tia_lfsr_counter: illegal WIDTH/TAP/NUM_DECODES combination");
    end

    logic [WIDTH-1:0]       r_out;
    logic [WIDTH-1:0]       r_stage;
    logic                   r_staged_wrap;
    logic                   r_wrap;
    logic [NUM_DECODES-1:0] r_decode;
    logic                   r_lockup;

    next_sel_e              w_sel;
    logic [WIDTH-1:0]       w_next_stage;
    logic                   w_next_wrap;
    logic [NUM_DECODES-1:0] w_match;

    tia_lfsr_decode #(
        .WIDTH         (WIDTH),
        .NUM_DECODES   (NUM_DECODES),
        .DECODE_VALUES (DECODE_VALUES)
    ) u_decode (
        .i_stage (r_stage),
        .o_match (w_match)
    );

    // Priority: clear, lock-up recovery, terminal wrap (overrides hold), hold, step.
    always_comb begin
        w_sel        = SEL_STEP;
        w_next_stage = RST_V;
        w_next_wrap  = 1'b0;
        if (bus.clear) begin
            w_sel = SEL_CLEAR;
        end else if (is_lockup(16'(r_out), MSB)) begin
            w_sel = SEL_LOCKUP;
        end else if (r_out == WRP_V) begin
            w_sel = SEL_WRAP;
        end else if (bus.hold) begin
            w_sel = SEL_HOLD;
        end else begin
            w_sel = SEL_STEP;
        end
        case (w_sel)
            SEL_CLEAR:  w_next_stage = RST_V;
            SEL_LOCKUP: w_next_stage = RST_V;
            SEL_WRAP: begin
                w_next_stage = RST_V;
                w_next_wrap  = 1'b1;
            end
            SEL_HOLD:   w_next_stage = r_out;
            SEL_STEP:   w_next_stage = {lfsr_feedback(16'(r_out), 4'(TAP_A), 4'(TAP_B)),
                                        r_out[WIDTH-1:1]};
            default:    w_next_stage = RST_V;
        endcase
    end

    // Phase 1: stage the next state; the lock-up flag is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage       <= RST_V;
            r_staged_wrap <= 1'b0;
            r_lockup      <= 1'b0;
        end else if (bus.s1_en) begin
            r_stage       <= w_next_stage;
            r_staged_wrap <= w_next_wrap;
            r_lockup      <= r_lockup | (w_sel == SEL_LOCKUP);
        end else begin
            r_stage       <= r_stage;
            r_staged_wrap <= r_staged_wrap;
            r_lockup      <= r_lockup;
        end
    end

    // Phase 2: commit the stage; the load hook overwrites out only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out    <= RST_V;
            r_wrap   <= 1'b0;
            r_decode <= {NUM_DECODES{1'b0}};
        end else if (bus.tst_load) begin
            r_out    <= bus.tst_value;
        end else if (bus.s2_en) begin
            r_out    <= r_stage;
            r_wrap   <= r_staged_wrap;
            r_decode <= w_match;
        end else begin
            r_out    <= r_out;
        end
    end

    assign bus.out    = r_out;
    assign bus.wrap   = r_wrap;
    assign bus.decode = r_decode;
    assign bus.lockup = r_lockup;

endmodule
